// File: rtl/ifm_window_gen.sv
// 3x3 sliding-window generator for a raster-scanned IFM stream (stride 1, no padding).
// Two line buffers feed a 3x3 register window; a valid/ready handshake is used on both sides.
module ifm_window_gen #(
   parameter int IFM_WIDTH   = 8,
   parameter int IMG_W       = 8,
   parameter int IMG_H       = 8,
   parameter int PE_ARR_SIZE = 9
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic signed [IFM_WIDTH-1:0]                pix_in,
   input  logic                                       pix_valid,
   output logic                                       pix_ready,
   output logic signed [PE_ARR_SIZE-1:0][IFM_WIDTH-1:0] win_out,
   output logic                                       win_valid,
   input  logic                                       win_ready,
   output logic                                       frame_done
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   typedef logic signed [IFM_WIDTH-1:0] pix_t;

   generate
      if (PE_ARR_SIZE != 9) begin : g_bad_cfg
         $error("ifm_window_gen: PE_ARR_SIZE must be 9 for a 3x3 window");
      end
   endgenerate

   logic [CW-1:0]                           col_q, col_d;
   logic [RW-1:0]                           row_q, row_d;
   logic [2:0][2:0][IFM_WIDTH-1:0]          win_q, win_d;
   logic [PE_ARR_SIZE-1:0][IFM_WIDTH-1:0]   out_q, out_d;
   logic                                    win_valid_q, win_valid_d;
   logic                                    frame_done_q, frame_done_d;

   pix_t lb_top_q [IMG_W];
   pix_t lb_mid_q [IMG_W];
   pix_t lb_top_d, lb_mid_d;
   pix_t col_top, col_mid;

   logic acc;
   logic last_col, last_row;

   assign pix_ready  = !win_valid_q || win_ready;
   assign acc        = pix_valid && pix_ready;
   assign win_out    = out_q;
   assign win_valid  = win_valid_q;
   assign frame_done = frame_done_q;

   assign col_top  = lb_top_q[col_q];
   assign col_mid  = lb_mid_q[col_q];
   assign last_col = (col_q == CW'(IMG_W - 1));
   assign last_row = (row_q == RW'(IMG_H - 1));

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      win_d        = win_q;
      out_d        = out_q;
      win_valid_d  = win_valid_q && !win_ready;
      frame_done_d = 1'b0;
      lb_top_d     = col_mid;
      lb_mid_d     = pix_in;

      if (acc) begin
         // Each row shifts left; the new rightmost column is top/mid line buffer plus the live pixel.
         win_d[0] = {col_top, win_q[0][2:1]};
         win_d[1] = {col_mid, win_q[1][2:1]};
         win_d[2] = {pix_in,  win_q[2][2:1]};

         if (last_col) begin
            col_d = '0;
            if (last_row) begin
               row_d        = '0;
               frame_done_d = 1'b1;
            end else begin
               row_d = row_q + RW'(1);
            end
         end else begin
            col_d = col_q + CW'(1);
         end

         // The row/col gates keep stale rows and row-wrapped columns out of the output.
         if ((row_q >= RW'(2)) && (col_q >= CW'(2))) begin
            out_d       = {win_d[2], win_d[1], win_d[0]};
            win_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         win_q        <= '0;
         out_q        <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         win_q        <= win_d;
         out_q        <= out_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Line-buffer contents are never observed before being rewritten, so they carry no reset.
   always_ff @(posedge clk) begin
      if (acc) begin
         lb_top_q[col_q] <= lb_top_d;
         lb_mid_q[col_q] <= lb_mid_d;
      end
   end

endmodule

// File: tb/tb_ifm_window_gen.sv
// Scoreboard bench for ifm_window_gen: a 4x4 instance for directed frames and an 8x8 instance
// for a frame with random valid/ready gaps.
module tb_ifm_window_gen;

   typedef logic [8:0][7:0] win_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic signed [7:0] pix_in4 = '0;
   logic              pix_valid4 = 1'b0;
   logic              pix_ready4;
   win_t              win_out4;
   logic              win_valid4;
   logic              win_ready4 = 1'b1;
   logic              frame_done4;

   logic signed [7:0] pix_in8 = '0;
   logic              pix_valid8 = 1'b0;
   logic              pix_ready8;
   win_t              win_out8;
   logic              win_valid8;
   logic              win_ready8 = 1'b1;
   logic              frame_done8;

   int   tests_run    = 0;
   int   tests_failed = 0;
   int   cycle_cnt    = 0;
   int   fd_due4      = -1;
   int   fd_due8      = -1;
   int   fd_count4    = 0;
   int   pop_count4   = 0;
   int   pop_count8   = 0;
   bit   rand_mode    = 1'b0;

   logic [7:0] frame4 [4][4];
   logic [7:0] frame8 [8][8];
   win_t exp4 [$];
   win_t exp8 [$];
   win_t got4 [$];

   ifm_window_gen #(.IFM_WIDTH(8), .IMG_W(4), .IMG_H(4), .PE_ARR_SIZE(9)) dut4 (
      .clk(clk), .rst(rst),
      .pix_in(pix_in4), .pix_valid(pix_valid4), .pix_ready(pix_ready4),
      .win_out(win_out4), .win_valid(win_valid4), .win_ready(win_ready4),
      .frame_done(frame_done4)
   );

   ifm_window_gen #(.IFM_WIDTH(8), .IMG_W(8), .IMG_H(8), .PE_ARR_SIZE(9)) dut8 (
      .clk(clk), .rst(rst),
      .pix_in(pix_in8), .pix_valid(pix_valid8), .pix_ready(pix_ready8),
      .win_out(win_out8), .win_valid(win_valid8), .win_ready(win_ready8),
      .frame_done(frame_done8)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] req);
      tests_run++;
      if (act !== req) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   function automatic win_t model_win(input int which, input int r, input int c);
      win_t w;
      for (int kr = 0; kr < 3; kr++)
         for (int kc = 0; kc < 3; kc++)
            w[3*kr+kc] = (which == 4) ? frame4[r-2+kr][c-2+kc] : frame8[r-2+kr][c-2+kc];
      return w;
   endfunction

   // Holds the pixel until accepted; on acceptance updates the frame model and expectations.
   task automatic applyStimulus(input int which, input int r, input int c, input logic [7:0] val);
      bit done = 1'b0;
      int guard = 0;
      while (!done) begin
         @(negedge clk);
         if (which == 4) begin pix_valid4 = 1'b1; pix_in4 = val; end
         else            begin pix_valid8 = 1'b1; pix_in8 = val; end
         #2;
         if ((which == 4) ? pix_ready4 : pix_ready8) begin
            done = 1'b1;
            if (which == 4) frame4[r][c] = val; else frame8[r][c] = val;
            if (r >= 2 && c >= 2) begin
               if (which == 4) exp4.push_back(model_win(4, r, c));
               else            exp8.push_back(model_win(8, r, c));
            end
            if (which == 4 && r == 3 && c == 3) fd_due4 = cycle_cnt + 1;
            if (which == 8 && r == 7 && c == 7) fd_due8 = cycle_cnt + 1;
         end else if (++guard > 200) begin
            checkOutput("pixel accept timeout", 72'd0, 72'd1);
            done = 1'b1;
         end
      end
   endtask

   task automatic idle(input int which, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (which == 4) pix_valid4 = 1'b0; else pix_valid8 = 1'b0;
      end
   endtask

   task automatic send_frame4(input int base);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            applyStimulus(4, r, c, 8'(base + 4*r + c));
   endtask

   task automatic wait_drain(input int which, input string name);
      int g = 0;
      while (((which == 4) ? exp4.size() : exp8.size()) != 0 && g < 100) begin
         @(negedge clk);
         #3;
         g++;
      end
      checkOutput(name, 72'((which == 4) ? exp4.size() : exp8.size()), 72'd0);
   endtask

   // Monitor for the 4x4 instance: pops on every handshake and tracks frame_done pulses.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (win_valid4 && win_ready4) begin
            if (exp4.size() == 0) checkOutput("dut4 unexpected window", win_out4, 72'd0);
            else                  checkOutput("dut4 window", win_out4, exp4.pop_front());
            got4.push_back(win_out4);
            pop_count4++;
         end
         if (frame_done4) fd_count4++;
         if (cycle_cnt == fd_due4)  checkOutput("dut4 frame_done pulse", 72'(frame_done4), 72'd1);
         else if (frame_done4)      checkOutput("dut4 frame_done spurious", 72'(frame_done4), 72'd0);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (win_valid8 && win_ready8) begin
            if (exp8.size() == 0) checkOutput("dut8 unexpected window", win_out8, 72'd0);
            else                  checkOutput("dut8 window", win_out8, exp8.pop_front());
            pop_count8++;
         end
         if (cycle_cnt == fd_due8)  checkOutput("dut8 frame_done pulse", 72'(frame_done8), 72'd1);
         else if (frame_done8)      checkOutput("dut8 frame_done spurious", 72'(frame_done8), 72'd0);
      end
   end

   // Random downstream back-pressure for the 8x8 instance.
   initial begin
      forever begin
         @(negedge clk);
         win_ready8 = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      win_t first_win, last_win, fifth_win;
      int   start, fd_start;
      first_win = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
      last_win  = {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5};
      fifth_win = {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104, 8'd102, 8'd101, 8'd100};

      repeat (3) @(negedge clk);
      #2;
      checkOutput("reset win_valid", 72'(win_valid4), 72'd0);
      checkOutput("reset pix_ready", 72'(pix_ready4), 72'd1);
      checkOutput("reset frame_done", 72'(frame_done4), 72'd0);
      checkOutput("reset win_out", win_out4, 72'd0);
      checkOutput("reset win_valid dut8", 72'(win_valid8), 72'd0);
      @(negedge clk);
      rst = 1'b0;

      // Scenario 1: plain 4x4 frame, always ready.
      got4.delete();
      start = pop_count4; fd_start = fd_count4;
      send_frame4(0);
      idle(4, 1);
      wait_drain(4, "s1 drain");
      checkOutput("s1 window count", 72'(pop_count4 - start), 72'd4);
      checkOutput("s1 first window", got4[0], first_win);
      checkOutput("s1 last window", got4[3], last_win);
      checkOutput("s1 frame_done count", 72'(fd_count4 - fd_start), 72'd1);

      // Scenario 2: downstream stalls for five cycles after the first window.
      got4.delete();
      start = pop_count4;
      for (int p = 0; p < 10; p++) applyStimulus(4, p / 4, p % 4, 8'(p));
      win_ready4 = 1'b0;
      applyStimulus(4, 2, 2, 8'd10);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         pix_valid4 = 1'b1;
         pix_in4    = 8'd11;
         #2;
         checkOutput("s2 stall pix_ready", 72'(pix_ready4), 72'd0);
         checkOutput("s2 stall win_valid", 72'(win_valid4), 72'd1);
         checkOutput("s2 stall win_out", win_out4, first_win);
      end
      @(negedge clk);
      pix_valid4 = 1'b0;
      win_ready4 = 1'b1;
      for (int p = 11; p < 16; p++) applyStimulus(4, p / 4, p % 4, 8'(p));
      idle(4, 1);
      wait_drain(4, "s2 drain");
      checkOutput("s2 window count", 72'(pop_count4 - start), 72'd4);
      checkOutput("s2 last window", got4[3], last_win);

      // Scenario 3: negative pixel values keep their sign.
      got4.delete();
      send_frame4(-128);
      idle(4, 1);
      wait_drain(4, "s3 drain");
      checkOutput("s3 lane0 signed", 72'(got4[0][0]), 72'(8'h80));
      checkOutput("s3 lane8 signed", 72'(got4[0][8]), 72'(8'h8A));

      // Scenario 4: two frames back-to-back.
      got4.delete();
      start = pop_count4; fd_start = fd_count4;
      send_frame4(0);
      send_frame4(100);
      idle(4, 1);
      wait_drain(4, "s4 drain");
      checkOutput("s4 window count", 72'(pop_count4 - start), 72'd8);
      checkOutput("s4 fifth window", got4[4], fifth_win);
      checkOutput("s4 frame_done count", 72'(fd_count4 - fd_start), 72'd2);

      // Scenario 5: reset mid-frame, then a fresh frame.
      got4.delete();
      start = pop_count4;
      for (int p = 0; p < 10; p++) applyStimulus(4, p / 4, p % 4, 8'(p + 50));
      @(negedge clk);
      rst = 1'b1;
      pix_valid4 = 1'b0;
      #2;
      checkOutput("s5 reset win_valid", 72'(win_valid4), 72'd0);
      checkOutput("s5 reset win_out", win_out4, 72'd0);
      @(negedge clk);
      rst = 1'b0;
      send_frame4(0);
      idle(4, 1);
      wait_drain(4, "s5 drain");
      checkOutput("s5 window count", 72'(pop_count4 - start), 72'd4);
      checkOutput("s5 first window", got4[0], first_win);

      // Scenario 6: 8x8 frame with random input gaps and random back-pressure.
      start = pop_count8;
      rand_mode = 1'b1;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (gap > 0) idle(8, gap);
            applyStimulus(8, r, c, 8'($urandom_range(0, 255)));
         end
      idle(8, 1);
      wait_drain(8, "s6 drain");
      rand_mode = 1'b0;
      checkOutput("s6 window count", 72'(pop_count8 - start), 72'd36);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
